posit_extract_pipe: RTL and testbench

POSIT_EXTRACT_PIPE -- requirements
Module: posit_extract_pipe

---
 rtl/posit_extract_pipe.sv | 230 +++++++++++++++++++++++
 tb/tb_posit_extract_pipe.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_extract_pipe.sv
// ----------------------------------------------------------------------------
// posit_extract_pipe
//
// Two-stage valid/ready pipeline that splits a posit word into its fields.
// Stage 1 captures the sign, the magnitude (two's complement negated when the
// sign is set) and the zero/NaR flags. Stage 2 decodes the regime run and
// slices out exponent and fraction, producing the effective exponent
// regime*2^ES + exp.
//
// Parameters:
//   N   posit word width (N >= ES+3)
//   ES  exponent field width
//   Bs  derived, $clog2(N)
//   M   derived, N-ES-2 (mantissa width including hidden bit)
//
// Ports:
//   clk        sole clock, rising edge
//   reset      asynchronous active-high reset
//   in_valid   input word present
//   in_ready   block accepts a word this cycle
//   in         posit word (two's complement)
//   out_valid  extracted fields present
//   out_ready  downstream accepts the fields this cycle
//   Sin        sign bit
//   regime     signed regime value k
//   exp        exponent field, zero-filled where truncated
//   mant       {1'b1, fraction}, fraction left-aligned
//   eff_e      signed effective exponent
//   zero       word is posit zero
//   nar        word is NaR
//   cnt_zero   (POSIT_EXTRACT_STATS_EN only) saturating count of zero outputs
//   cnt_nar    (POSIT_EXTRACT_STATS_EN only) saturating count of NaR outputs
//
// Optional feature macro: POSIT_EXTRACT_STATS_EN
// ----------------------------------------------------------------------------
module posit_extract_pipe #(
    parameter int N  = 8,
    parameter int ES = 4,
    localparam int Bs = $clog2(N),
    localparam int M  = N - ES - 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 Sin,
    output logic signed [Bs:0]   regime,
    output logic [ES-1:0]        exp,
    output logic [M-1:0]         mant,
    output logic signed [Bs+ES:0] eff_e,
    output logic                 zero,
    output logic                 nar
`ifdef POSIT_EXTRACT_STATS_EN
    ,
    output logic [15:0]          cnt_zero,
    output logic [15:0]          cnt_nar
`endif
);

    // Handshake: stage 2 frees up when empty or drained; stage 1 advances
    // into stage 2 under that condition, so in_ready never looks at in_valid.
    logic s2Load;
    logic s1Advance;
    logic inXfer;

    logic          s1Valid_q;
    logic          s1Sin_q;
    logic [N-2:0]  s1Abs_q;
    logic          s1Zero_q;
    logic          s1Nar_q;
    logic [N-2:0]  s1Abs_d;
    logic          s1Zero_d;
    logic          s1Nar_d;

    logic                 outValid_q;
    logic                 sin_q;
    logic signed [Bs:0]   regime_q;
    logic [ES-1:0]        exp_q;
    logic [M-1:0]         mant_q;
    logic signed [Bs+ES:0] effE_q;
    logic                 zero_q;
    logic                 nar_q;

    logic signed [Bs:0]   regime_d;
    logic [ES-1:0]        exp_d;
    logic [M-1:0]         mant_d;
    logic signed [Bs+ES:0] effE_d;

    // Decode scratch
    logic [N-2:0] body;
    logic [N-2:0] afterRegime;
    logic [N-2:0] afterExp;
    logic         runBit;
    logic         runStop;
    int           runLen;
    int           regimeInt;
    int           effInt;

    assign s2Load    = !outValid_q || out_ready;
    assign s1Advance = s1Valid_q && s2Load;
    assign in_ready  = !s1Valid_q || s1Advance;
    assign inXfer    = in_valid && in_ready;

    // Only the low N-1 magnitude bits matter: the top bit is set solely for
    // NaR, which is flagged separately, and negation modulo 2^(N-1) depends
    // only on the low bits of the input.
    always_comb begin
        s1Abs_d  = in[N-1] ? -in[N-2:0] : in[N-2:0];
        s1Zero_d = (in == '0);
        s1Nar_d  = (in == {1'b1, {(N-1){1'b0}}});
    end

    // Stage 1 register: captures a word whenever one is transferred in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1Valid_q <= 1'b0;
            s1Sin_q   <= 1'b0;
            s1Abs_q   <= '0;
            s1Zero_q  <= 1'b0;
            s1Nar_q   <= 1'b0;
        end else begin
            if (in_ready) begin
                s1Valid_q <= in_valid;
            end
            if (inXfer) begin
                s1Sin_q  <= in[N-1];
                s1Abs_q  <= s1Abs_d;
                s1Zero_q <= s1Zero_d;
                s1Nar_q  <= s1Nar_d;
            end
        end
    end

    // Regime decode: measure the run starting below the sign bit, then shift
    // the run plus its terminator out so exponent and fraction are left
    // aligned. A run reaching bit 0 shifts everything out, giving zero fill.
    always_comb begin
        body    = s1Abs_q;
        runBit  = body[N-2];
        runLen  = 1;
        runStop = 1'b0;
        for (int i = N - 3; i >= 0; i--) begin
            if (!runStop) begin
                if (body[i] == runBit) begin
                    runLen = runLen + 1;
                end else begin
                    runStop = 1'b1;
                end
            end
        end
        regimeInt   = runBit ? (runLen - 1) : -runLen;
        afterRegime = body << (runLen + 1);
        afterExp    = afterRegime << ES;
        exp_d       = ES'(afterRegime >> (N - 1 - ES));
        mant_d      = M'({1'b1, afterExp} >> (N - M));
        effInt      = regimeInt * (1 << ES) + int'(exp_d);
        regime_d    = (Bs + 1)'(regimeInt);
        effE_d      = (Bs + ES + 1)'(effInt);
        if (s1Zero_q || s1Nar_q) begin
            regime_d = '0;
            exp_d    = '0;
            mant_d   = '0;
            effE_d   = '0;
        end
    end

    // Stage 2 register: holds the decoded fields stable while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outValid_q <= 1'b0;
            sin_q      <= 1'b0;
            regime_q   <= '0;
            exp_q      <= '0;
            mant_q     <= '0;
            effE_q     <= '0;
            zero_q     <= 1'b0;
            nar_q      <= 1'b0;
        end else if (s2Load) begin
            outValid_q <= s1Valid_q;
            if (s1Valid_q) begin
                sin_q    <= s1Sin_q;
                regime_q <= regime_d;
                exp_q    <= exp_d;
                mant_q   <= mant_d;
                effE_q   <= effE_d;
                zero_q   <= s1Zero_q;
                nar_q    <= s1Nar_q;
            end
        end
    end

    assign out_valid = outValid_q;
    assign Sin       = sin_q;
    assign regime    = regime_q;
    assign exp       = exp_q;
    assign mant      = mant_q;
    assign eff_e     = effE_q;
    assign zero      = zero_q;
    assign nar       = nar_q;

`ifdef POSIT_EXTRACT_STATS_EN
    logic        outXfer;
    logic [15:0] cntZero_q;
    logic [15:0] cntNar_q;

    assign outXfer = outValid_q && out_ready;

    // Saturating counters of zero and NaR words handed downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cntZero_q <= '0;
            cntNar_q  <= '0;
        end else begin
            if (outXfer && zero_q && cntZero_q != 16'hFFFF) begin
                cntZero_q <= cntZero_q + 16'd1;
            end
            if (outXfer && nar_q && cntNar_q != 16'hFFFF) begin
                cntNar_q <= cntNar_q + 16'd1;
            end
        end
    end

    assign cnt_zero = cntZero_q;
    assign cnt_nar  = cntNar_q;
`endif

endmodule

// File: tb/tb_posit_extract_pipe.sv
// ----------------------------------------------------------------------------
// tb_posit_extract_pipe
//
// Bench for posit_extract_pipe at N=8, ES=4. Expected field sets are queued
// when a word is accepted and popped by a monitor when the block hands a
// result downstream. The monitor also watches that stalled outputs hold.
// ----------------------------------------------------------------------------
module tb_posit_extract_pipe;

    typedef struct packed {
        logic       sin;
        logic [3:0] regime;
        logic [3:0] exp;
        logic [1:0] mant;
        logic [7:0] effE;
        logic       zero;
        logic       nar;
    } fields_t;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              out_valid;
    logic              out_ready;
    logic              Sin;
    logic signed [3:0] regime;
    logic [3:0]        expF;
    logic [1:0]        mant;
    logic signed [7:0] eff_e;
    logic              zero;
    logic              nar;
`ifdef POSIT_EXTRACT_STATS_EN
    logic [15:0]       cnt_zero;
    logic [15:0]       cnt_nar;
`endif

    int checks = 0;
    int errors = 0;
    fields_t sb[$];

    // Monitor state for stall-stability checks
    bit      stallSeen = 0;
    fields_t stallHeld;

    posit_extract_pipe #(.N(8), .ES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sin       (Sin),
        .regime    (regime),
        .exp       (expF),
        .mant      (mant),
        .eff_e     (eff_e),
        .zero      (zero),
        .nar       (nar)
`ifdef POSIT_EXTRACT_STATS_EN
        ,
        .cnt_zero  (cnt_zero),
        .cnt_nar   (cnt_nar)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference decode written as a bit walk over the magnitude.
    function automatic fields_t model(input logic [7:0] w);
        fields_t e;
        logic [7:0] a;
        logic b;
        int pos;
        int k;
        int ev;
        int f;
        int rg;
        e = '0;
        e.sin = w[7];
        if (w == 8'h00) begin
            e.zero = 1'b1;
            return e;
        end
        if (w == 8'h80) begin
            e.nar = 1'b1;
            return e;
        end
        a = w[7] ? (~w + 8'd1) : w;
        b = a[6];
        pos = 6;
        k = 0;
        while (pos >= 0 && a[pos] == b) begin
            k++;
            pos--;
        end
        rg = b ? k - 1 : -k;
        pos--;
        ev = 0;
        for (int j = 0; j < 4; j++) begin
            ev = ev * 2 + ((pos >= 0) ? int'(a[pos]) : 0);
            pos--;
        end
        f = (pos >= 0) ? int'(a[pos]) : 0;
        e.regime = 4'(rg);
        e.exp    = 4'(ev);
        e.mant   = {1'b1, f[0]};
        e.effE   = 8'(rg * 16 + ev);
        return e;
    endfunction

    // Scoreboard monitor: compares every output transfer and checks that
    // stalled outputs do not move.
    always @(negedge clk) begin
        fields_t obs;
        fields_t want;
        obs = {Sin, regime, expF, mant, eff_e, zero, nar};
        if (reset) begin
            stallSeen = 0;
        end else begin
            if (stallSeen) begin
                checks++;
                if (out_valid !== 1'b1 || obs !== stallHeld) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: got valid=%b fields=%h, expected valid=1 fields=%h",
                             out_valid, obs, stallHeld);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_output: got fields=%h, expected no output", obs);
                end else begin
                    want = sb.pop_front();
                    if (obs !== want) begin
                        errors++;
                        $display("[TB] FAIL fields: got %h (S=%b k=%0d e=%h m=%b ee=%0d z=%b n=%b), expected %h",
                                 obs, Sin, regime, expF, mant, eff_e, zero, nar, want);
                    end
                end
            end
            stallSeen = out_valid && !out_ready;
            stallHeld = obs;
        end
    end

    // Offer one word and queue its expectation at the acceptance edge.
    task automatic sendWord(input logic [7:0] w, input fields_t e);
        bit done;
        int n;
        in_valid = 1'b1;
        in_data  = w;
        done = 0;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            done = in_ready;
            if (done) sb.push_back(e);
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_timeout: got in_ready=0 for 50 cycles, expected acceptance of %h", w);
        end
    endtask

    // Let the pipe empty out, bounded.
    task automatic waitDrain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d words outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || {Sin, regime, expF, mant, eff_e, zero, nar} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got valid=%b fields=%h, expected 0 and 0",
                     out_valid, {Sin, regime, expF, mant, eff_e, zero, nar});
        end
`ifdef POSIT_EXTRACT_STATS_EN
        checks++;
        if (cnt_zero !== 16'd0 || cnt_nar !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_counters: got %0d/%0d, expected 0/0", cnt_zero, cnt_nar);
        end
`endif
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_reset: got %b, expected 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        sendWord(8'hB0, '{sin: 1'b1, regime: 4'd0, exp: 4'b1000, mant: 2'b10,
                          effE: 8'd8, zero: 1'b0, nar: 1'b0});
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL latency_early: got out_valid=%b one cycle after accept, expected 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL latency: got out_valid=%b two cycles after accept, expected 1", out_valid);
        end
        @(posedge clk);
        #1;
        waitDrain();
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        fields_t    exps  [3];
        logic [5:0] hist;
        words[0] = 8'h40;
        words[1] = 8'h01;
        words[2] = 8'h7F;
        exps[0] = '{sin: 1'b0, regime: 4'd0,  exp: 4'd0, mant: 2'b10, effE: 8'd0,   zero: 1'b0, nar: 1'b0};
        exps[1] = '{sin: 1'b0, regime: -4'sd6, exp: 4'd0, mant: 2'b10, effE: -8'sd96, zero: 1'b0, nar: 1'b0};
        exps[2] = '{sin: 1'b0, regime: 4'd6,  exp: 4'd0, mant: 2'b10, effE: 8'd96,  zero: 1'b0, nar: 1'b0};
        hist = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin
                in_valid = 1'b1;
                in_data  = words[c];
                sb.push_back(exps[c]);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            hist[c] = out_valid;
            if (c < 3) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL b2b_ready: got in_ready=%b for word %0d, expected 1", in_ready, c);
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (hist !== 6'b011100) begin
            errors++;
            $display("[TB] FAIL b2b_timing: got valid history %b, expected 011100", hist);
        end
        waitDrain();
    endtask

    task automatic test_zero_nar();
        sendWord(8'h00, '{sin: 1'b0, regime: 4'd0, exp: 4'd0, mant: 2'b00,
                          effE: 8'd0, zero: 1'b1, nar: 1'b0});
        sendWord(8'h80, '{sin: 1'b1, regime: 4'd0, exp: 4'd0, mant: 2'b00,
                          effE: 8'd0, zero: 1'b0, nar: 1'b1});
        in_valid = 1'b0;
        waitDrain();
`ifdef POSIT_EXTRACT_STATS_EN
        checks++;
        if (cnt_zero !== 16'd1 || cnt_nar !== 16'd1) begin
            errors++;
            $display("[TB] FAIL stats: got cnt_zero=%0d cnt_nar=%0d, expected 1/1", cnt_zero, cnt_nar);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [7:0] words [3];
        int idx;
        bit acc;
        words[0] = 8'h48;
        words[1] = 8'h21;
        words[2] = 8'h9C;
        idx = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 3);
            in_data  = words[idx];
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) sb.push_back(model(words[idx]));
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        @(negedge clk);
        checks++;
        if (idx !== 2 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL backpressure: got accepted=%0d in_ready=%b, expected 2 and 0", idx, in_ready);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        sendWord(words[2], model(words[2]));
        in_valid = 1'b0;
        waitDrain();
    endtask

    task automatic test_random();
        logic [7:0] w;
        bit pending;
        int sent;
        pending = 0;
        sent = 0;
        w = 8'h00;
        for (int cyc = 0; cyc < 400 && sent < 40; cyc++) begin
            if (!pending && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 7))
                    0: w = 8'h00;
                    1: w = 8'h80;
                    2: w = 8'h81;
                    default: w = 8'($urandom);
                endcase
                pending = 1;
            end
            in_valid  = pending;
            in_data   = w;
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (pending && in_ready) begin
                sb.push_back(model(w));
                pending = 0;
                sent++;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (sent != 40) begin
            errors++;
            $display("[TB] FAIL random_sent: got %0d words accepted, expected 40", sent);
        end
        waitDrain();
    endtask

    task automatic test_reset_inflight();
        int seen;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        @(posedge clk);
        #1;
        in_data = 8'h33;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_async: got out_valid=%b in_ready=%b, expected 0 and 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("[TB] FAIL reset_discard: got %0d valid cycles after reset, expected 0", seen);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_zero_nar();
        test_backpressure();
        test_random();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion by 200000, expected earlier finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
